// File: rtl/mem_access_seq_pkg.sv
// ---------------------------------------------------------------------------
// rv32_mem_pkg
// Shared constants and types for the RV32 memory-stage sequencer.
//   OP_LOAD / OP_STORE : major opcodes that need a data-memory access
//   F3_*               : funct3 encodings for access size and signedness
//   seq_state_t        : sequencer FSM states
//   load_f3_ok / store_f3_ok : funct3 legality checks per opcode
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } seq_state_t;

    // LB, LH, LW, LBU, LHU are the only defined load widths
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // SB, SH, SW are the only defined store widths
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// ---------------------------------------------------------------------------
// mem_access_seq_if
// Data-memory port of the memory-stage sequencer (req/gnt/rvalid protocol).
//   mem_req_o    request, held until mem_gnt_i
//   mem_we_o     1 = store
//   mem_addr_o   word-aligned address
//   mem_be_o     byte enables
//   mem_wdata_o  lane-replicated store data
//   mem_gnt_i    request accepted this cycle
//   mem_rvalid_i load data valid
//   mem_rdata_i  load data word
// master : the sequencer side; slave : the memory side.
// ---------------------------------------------------------------------------
interface mem_access_seq_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_access_seq_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational lane logic for both directions of a memory access.
//   Load side : rdata, ld_offset, ld_funct3 -> ld_data (aligned, extended)
//   Store side: st_data, st_offset, st_funct3 -> st_be, st_wdata (replicated)
// Halfwords only look at offset[1] and words always use lane 0, so low
// address bits below the access size have no effect here.
// ---------------------------------------------------------------------------
module load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    output logic [31:0] ld_data,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_funct3,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword out of the returned word, then
    // sign- or zero-extend it according to the load flavour.
    always_comb begin
        byte_sel = rdata[7:0];
        case (ld_offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'h0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'h0, half_sel};
            default: ld_data = rdata;
        endcase
    end

    // Stores replicate the datum across every lane so the byte enables
    // alone select what memory actually writes.
    always_comb begin
        case (st_funct3)
            F3_B: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
// Memory-stage sequencer for the RV32 pipeline. Accepts the instruction
// leaving execute, performs the data-memory access it needs over a
// req/gnt/rvalid port, and hands the instruction (plus aligned load data)
// to writeback. Non-memory instructions pass through in one cycle.
//
// Parameters
//   TIMEOUT  cycles to wait for mem_rvalid_i after grant before aborting (>=2)
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   instr_i        instruction from execute
//   instr_valid_i  instr_i/addr_i/wdata_i valid
//   addr_i         effective byte address
//   wdata_i        store data (rs2)
//   stall_o        hold upstream while an access is in flight
//   instr_wb_o     instruction forwarded to writeback
//   wb_valid_o     1-cycle completion pulse
//   load_data_o    aligned, extended load result (0 for non-loads)
//   err_o          response timeout, pulses with wb_valid_o
//   misalign_o     misaligned access, pulses with wb_valid_o
//   mem            data-memory port (mem_access_seq_if.master)
// Configuration
//   MEM_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//   skip the bus and complete next cycle with misalign_o. When undefined,
//   misalign_o is tied 0 and the low address bits below the size are ignored.
// ---------------------------------------------------------------------------
module mem_access_seq
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] instr_wb_o,
    output logic        wb_valid_o,
    output logic [31:0] load_data_o,
    output logic        err_o,
    output logic        misalign_o,
    mem_access_seq_if.master mem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_t    state;
    logic [CW-1:0] resp_cnt;
    logic [31:0]   instr_q;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [1:0]    offset;
    logic          is_load;
    logic          is_store;
    logic          misaligned;
    logic          go_mem;
    logic [31:0]   ld_data;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;

    // Decode the incoming instruction. Undefined funct3 values fall out of
    // is_load/is_store and are therefore treated as plain pass-through.
    always_comb begin
        opcode     = instr_i[6:0];
        funct3     = instr_i[14:12];
        offset     = addr_i[1:0];
        is_load    = (opcode == OP_LOAD) && load_f3_ok(funct3);
        is_store   = (opcode == OP_STORE) && store_f3_ok(funct3);
        misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (funct3)
            F3_H, F3_HU: misaligned = offset[0];
            F3_W:        misaligned = (offset != 2'b00);
            default:     misaligned = 1'b0;
        endcase
`endif
        go_mem = (is_load || is_store) && !misaligned;
    end

    // Upstream must freeze as soon as a bus access is accepted and stay
    // frozen until the completion has been registered.
    always_comb begin
        stall_o = (state != ST_IDLE) || (instr_valid_i && go_mem);
    end

    load_align u_align (
        .rdata     (mem.mem_rdata_i),
        .ld_offset (offset_q),
        .ld_funct3 (funct3_q),
        .ld_data   (ld_data),
        .st_data   (wdata_i),
        .st_offset (offset),
        .st_funct3 (funct3),
        .st_be     (st_be),
        .st_wdata  (st_wdata)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Sequencer FSM. All bus and writeback outputs are registered here.
    // Bus fields are captured at accept and held until grant; the response
    // counter only runs in RESP and aborts the load once it hits TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            resp_cnt        <= '0;
            instr_q         <= '0;
            funct3_q        <= '0;
            offset_q        <= '0;
            instr_wb_o      <= '0;
            wb_valid_o      <= 1'b0;
            load_data_o     <= '0;
            err_o           <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_be_o    <= '0;
            mem.mem_wdata_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        instr_q  <= instr_i;
                        funct3_q <= funct3;
                        offset_q <= offset;
                        if (go_mem) begin
                            mem.mem_req_o   <= 1'b1;
                            mem.mem_we_o    <= is_store;
                            mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem.mem_be_o    <= st_be;
                            mem.mem_wdata_o <= st_wdata;
                            state           <= ST_REQ;
                        end else begin
                            wb_valid_o  <= 1'b1;
                            instr_wb_o  <= instr_i;
                            load_data_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign_q  <= (is_load || is_store) && misaligned;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_gnt_i) begin
                        mem.mem_req_o <= 1'b0;
                        if (mem.mem_we_o) begin
                            wb_valid_o  <= 1'b1;
                            instr_wb_o  <= instr_q;
                            load_data_o <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            resp_cnt <= '0;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem.mem_rvalid_i) begin
                        wb_valid_o  <= 1'b1;
                        instr_wb_o  <= instr_q;
                        load_data_o <= ld_data;
                        state       <= ST_IDLE;
                    end else if (resp_cnt == CW'(TIMEOUT - 1)) begin
                        wb_valid_o  <= 1'b1;
                        err_o       <= 1'b1;
                        instr_wb_o  <= instr_q;
                        load_data_o <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_access_seq
// Self-checking bench for mem_access_seq. Every accepted instruction pushes
// its expected writeback record onto a scoreboard queue; a monitor pops and
// compares on each wb_valid_o pulse. The main sequence also checks the bus
// fields, stall behaviour and completion latency cycle by cycle.
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the misalignment trap.
// ---------------------------------------------------------------------------
module tb_mem_access_seq;
    import rv32_mem_pkg::*;

    localparam int TIMEOUT = 12;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic        err;
        logic        mis;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] instr_wb_o;
    logic        wb_valid_o;
    logic [31:0] load_data_o;
    logic        err_o;
    logic        misalign_o;

    int          check_count = 0;
    int          error_count = 0;
    wb_exp_t     sb_q[$];
    wb_exp_t     exp_item;

    mem_access_seq_if bus ();

    mem_access_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .instr_wb_o    (instr_wb_o),
        .wb_valid_o    (wb_valid_o),
        .load_data_o   (load_data_o),
        .err_o         (err_o),
        .misalign_o    (misalign_o),
        .mem           (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {7'h05, 5'd6, 5'd7, f3, 5'd9, op};
    endfunction

    task automatic sb_push(input logic [31:0] instr, input logic [31:0] data,
                           input logic err, input logic mis);
        wb_exp_t e;
        e.instr = instr;
        e.data  = data;
        e.err   = err;
        e.mis   = mis;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation
    always @(negedge clk) begin
        if (wb_valid_o) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_item = sb_q.pop_front();
                check_output("sb_instr", instr_wb_o, exp_item.instr);
                check_output("sb_load_data", load_data_o, exp_item.data);
                check_output("sb_err", {31'h0, err_o}, {31'h0, exp_item.err});
                check_output("sb_misalign", {31'h0, misalign_o}, {31'h0, exp_item.mis});
            end
        end
    end

    // Drive one memory instruction through accept, grant and (for loads)
    // response, checking bus fields, stall and latency along the way.
    task automatic apply_stimulus(input logic [31:0] instr, addr, wdata, rdata,
                                  input int gnt_dly, rv_dly,
                                  input logic [3:0] exp_be,
                                  input logic [31:0] exp_wdata, exp_load,
                                  input logic exp_err);
        logic is_load;
        int   n;
        bit   seen;
        is_load       = (instr[6:0] == OP_LOAD);
        instr_i       = instr;
        addr_i        = addr;
        wdata_i       = wdata;
        instr_valid_i = 1'b1;
        sb_push(instr, (is_load && !exp_err) ? exp_load : 32'h0, exp_err, 1'b0);
        @(negedge clk);
        check_output("stall_accept", {31'h0, stall_o}, 32'd1);
        check_output("req_in_accept", {31'h0, bus.mem_req_o}, 32'd0);
        step();
        instr_valid_i = 1'b0;
        for (int k = 0; k <= gnt_dly; k++) begin
            if (k == gnt_dly) bus.mem_gnt_i = 1'b1;
            @(negedge clk);
            check_output("req_held", {31'h0, bus.mem_req_o}, 32'd1);
            check_output("addr", bus.mem_addr_o, {addr[31:2], 2'b00});
            check_output("we", {31'h0, bus.mem_we_o}, {31'h0, !is_load});
            check_output("stall_req", {31'h0, stall_o}, 32'd1);
            if (!is_load) begin
                check_output("be", {28'h0, bus.mem_be_o}, {28'h0, exp_be});
                check_output("wdata", bus.mem_wdata_o, exp_wdata);
            end
            step();
            bus.mem_gnt_i = 1'b0;
        end
        if (!is_load) begin
            @(negedge clk);
            check_output("store_wb_latency", {31'h0, wb_valid_o}, 32'd1);
            check_output("stall_after_store", {31'h0, stall_o}, 32'd0);
            check_output("req_dropped", {31'h0, bus.mem_req_o}, 32'd0);
        end else if (!exp_err) begin
            for (int k = 0; k <= rv_dly; k++) begin
                if (k == rv_dly) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = rdata;
                end
                @(negedge clk);
                check_output("no_early_wb", {31'h0, wb_valid_o}, 32'd0);
                check_output("stall_resp", {31'h0, stall_o}, 32'd1);
                step();
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = 32'h0;
            end
            @(negedge clk);
            check_output("load_wb_latency", {31'h0, wb_valid_o}, 32'd1);
        end else begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < TIMEOUT + 8) begin
                @(negedge clk);
                n++;
                if (wb_valid_o) seen = 1'b1;
                else step();
            end
            check_output("timeout_latency", n, TIMEOUT + 1);
            check_output("timeout_err", {31'h0, err_o}, 32'd1);
        end
        step();
    endtask

    // Non-memory (or trapped) instruction: completes next cycle, no bus
    task automatic apply_passthrough(input logic [31:0] instr, addr,
                                     input logic exp_mis, input logic chk_stall);
        instr_i       = instr;
        addr_i        = addr;
        wdata_i       = 32'h1111_2222;
        instr_valid_i = 1'b1;
        sb_push(instr, 32'h0, 1'b0, exp_mis);
        @(negedge clk);
        if (chk_stall) check_output("pass_stall", {31'h0, stall_o}, 32'd0);
        step();
        instr_valid_i = 1'b0;
        @(negedge clk);
        check_output("pass_wb_next", {31'h0, wb_valid_o}, 32'd1);
        check_output("pass_no_req", {31'h0, bus.mem_req_o}, 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        instr_i          = 32'h0;
        instr_valid_i    = 1'b0;
        addr_i           = 32'h0;
        wdata_i          = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_req", {31'h0, bus.mem_req_o}, 32'd0);
        check_output("rst_wb_valid", {31'h0, wb_valid_o}, 32'd0);
        check_output("rst_stall", {31'h0, stall_o}, 32'd0);
        check_output("rst_instr_wb", instr_wb_o, 32'h0);
        rst = 1'b0;
        step();

        // stores: full word, bytes and halfwords in different lanes
        apply_stimulus(mk(F3_W, OP_STORE), 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
                       4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        apply_stimulus(mk(F3_B, OP_STORE), 32'h103, 32'h1234565A, 32'h0, 0, 0,
                       4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0);
        apply_stimulus(mk(F3_B, OP_STORE), 32'h201, 32'h000000C3, 32'h0, 1, 0,
                       4'b0010, 32'hC3C3C3C3, 32'h0, 1'b0);
        apply_stimulus(mk(F3_H, OP_STORE), 32'h102, 32'hBEEF1234, 32'h0, 0, 0,
                       4'b1100, 32'h12341234, 32'h0, 1'b0);
        apply_stimulus(mk(F3_H, OP_STORE), 32'h300, 32'h0000ABCD, 32'h0, 0, 0,
                       4'b0011, 32'hABCDABCD, 32'h0, 1'b0);

        // loads against 0x80FF7F01
        apply_stimulus(mk(F3_B, OP_LOAD), 32'h3, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        apply_stimulus(mk(F3_BU, OP_LOAD), 32'h3, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'h00000080, 1'b0);
        apply_stimulus(mk(F3_B, OP_LOAD), 32'h1, 32'h0, 32'h80FF7F01, 0, 1,
                       4'b0, 32'h0, 32'h0000007F, 1'b0);
        apply_stimulus(mk(F3_H, OP_LOAD), 32'h2, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'hFFFF80FF, 1'b0);
        apply_stimulus(mk(F3_HU, OP_LOAD), 32'h0, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'h00007F01, 1'b0);
        apply_stimulus(mk(F3_W, OP_LOAD), 32'h40, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'h80FF7F01, 1'b0);

        // backpressure on grant and response
        apply_stimulus(mk(F3_W, OP_STORE), 32'h444, 32'h01234567, 32'h0, 5, 0,
                       4'b1111, 32'h01234567, 32'h0, 1'b0);
        apply_stimulus(mk(F3_H, OP_LOAD), 32'h802, 32'h0, 32'h80FF7F01, 5, 3,
                       4'b0, 32'h0, 32'hFFFF80FF, 1'b0);

        // response timeout, then a late rvalid that must be ignored
        apply_stimulus(mk(F3_W, OP_LOAD), 32'h500, 32'h0, 32'h0, 0, 0,
                       4'b0, 32'h0, 32'h0, 1'b1);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFEF00D;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("late_rvalid_ignored", {31'h0, wb_valid_o}, 32'd0);
            step();
        end
        bus.mem_rvalid_i = 1'b0;

        // non-memory and undefined-funct3 instructions pass straight through
        apply_passthrough(mk(3'b000, 7'b0010011), 32'h0, 1'b0, 1'b1);
        apply_passthrough(mk(3'b011, OP_LOAD), 32'h10, 1'b0, 1'b1);
        apply_passthrough(mk(3'b101, OP_STORE), 32'h10, 1'b0, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
        apply_passthrough(mk(F3_W, OP_LOAD), 32'h102, 1'b1, 1'b0);
        apply_passthrough(mk(F3_H, OP_STORE), 32'h101, 1'b1, 1'b0);
`else
        apply_stimulus(mk(F3_W, OP_LOAD), 32'h102, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'h80FF7F01, 1'b0);
        apply_stimulus(mk(F3_H, OP_STORE), 32'h101, 32'h00005577, 32'h0, 0, 0,
                       4'b0011, 32'h55775577, 32'h0, 1'b0);
`endif

        // reset while waiting for a response
        instr_i       = mk(F3_W, OP_LOAD);
        addr_i        = 32'h600;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_resp_req", {31'h0, bus.mem_req_o}, 32'd0);
        check_output("rst_resp_stall", {31'h0, stall_o}, 32'd0);
        check_output("rst_resp_instr_wb", instr_wb_o, 32'h0);
        check_output("rst_resp_load_data", load_data_o, 32'h0);
        step();
        rst              = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("rvalid_after_rst_ignored", {31'h0, wb_valid_o}, 32'd0);
            step();
        end
        bus.mem_rvalid_i = 1'b0;

        // reset while the request is pending drops mem_req_o at once
        instr_i       = mk(F3_W, OP_STORE);
        addr_i        = 32'h700;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        @(negedge clk);
        check_output("req_before_rst", {31'h0, bus.mem_req_o}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_output("req_dropped_by_rst", {31'h0, bus.mem_req_o}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // back in IDLE after reset
        apply_stimulus(mk(F3_B, OP_LOAD), 32'h2, 32'h0, 32'h80FF7F01, 0, 0,
                       4'b0, 32'h0, 32'hFFFFFFFF, 1'b0);

        repeat (2) step();
        check_output("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
